// File: rtl/warmboot_pkg.sv
// Shared types and constants for the warm-boot requester.
// Contents:
//   rx_state_t    - serial receiver states
//   parse_state_t - command parser / boot sequencer states
//   DEFAULT_MAGIC - first byte of a boot command
//   cmd_byte_ok   - nibble check on the command byte (high nibble == ~low nibble)
package warmboot_pkg;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   typedef enum logic [1:0] {
      P_IDLE,
      P_GOT_MAGIC,
      P_SETUP,
      P_PULSE
   } parse_state_t;

   localparam logic [7:0] DEFAULT_MAGIC = 8'hA5;

   function automatic logic cmd_byte_ok(input logic [7:0] b);
      return b[7:4] == ~b[3:0];
   endfunction

endpackage

// File: rtl/warmboot_uart_rx.sv
// 8N1 serial receiver with a 2-flop input synchronizer.
// Ports:
//   clk_i        - system clock
//   rst_in       - asynchronous active-low reset
//   rx_i         - serial line, idles high, asynchronous to clk_i
//   byte_o       - received byte, valid while byte_valid_o is high
//   byte_valid_o - one-cycle pulse in the cycle the good stop bit is sampled
//   frame_err_o  - one-cycle pulse in the cycle a low stop bit is sampled
module warmboot_uart_rx
   import warmboot_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk_i,
   input  logic       rst_in,
   input  logic       rx_i,
   output logic [7:0] byte_o,
   output logic       byte_valid_o,
   output logic       frame_err_o
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

   logic             rx_meta, rx_s;
   rx_state_t        state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [2:0]       bit_idx, bit_n;
   logic [7:0]       shreg, shreg_n;
   // Set after a framing error: hold in RX_STOP until the line returns high,
   // so a break (line stuck low) is not mistaken for a new start bit.
   logic             brk, brk_n;

   always_ff @(posedge clk_i or negedge rst_in) begin
      if (!rst_in) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         state   <= RX_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         brk     <= 1'b0;
      end else begin
         rx_meta <= rx_i;
         rx_s    <= rx_meta;
         state   <= state_n;
         cnt     <= cnt_n;
         bit_idx <= bit_n;
         shreg   <= shreg_n;
         brk     <= brk_n;
      end
   end

   always_comb begin
      state_n      = state;
      cnt_n        = cnt;
      bit_n        = bit_idx;
      shreg_n      = shreg;
      brk_n        = brk;
      byte_valid_o = 1'b0;
      frame_err_o  = 1'b0;
      case (state)
         RX_IDLE: begin
            if (!rx_s) begin
               state_n = RX_START;
               cnt_n   = '0;
            end
         end
         RX_START: begin
            // Mid-start-bit sample: a line already back high was a glitch.
            if (cnt == HALF_LAST) begin
               cnt_n   = '0;
               bit_n   = '0;
               state_n = rx_s ? RX_IDLE : RX_DATA;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         RX_DATA: begin
            if (cnt == BIT_LAST) begin
               cnt_n   = '0;
               shreg_n = {rx_s, shreg[7:1]};  // LSB arrives first
               if (bit_idx == 3'd7) begin
                  state_n = RX_STOP;
               end else begin
                  bit_n = bit_idx + 1'b1;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         RX_STOP: begin
            if (brk) begin
               if (rx_s) begin
                  brk_n   = 1'b0;
                  state_n = RX_IDLE;
               end
            end else if (cnt == BIT_LAST) begin
               cnt_n = '0;
               if (rx_s) begin
                  byte_valid_o = 1'b1;
                  state_n      = RX_IDLE;
               end else begin
                  frame_err_o = 1'b1;
                  brk_n       = 1'b1;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: state_n = RX_IDLE;
      endcase
   end

   assign byte_o = shreg;

endmodule

// File: rtl/warmboot_requester.sv
// Warm-boot initiator: receives a two-byte command (MAGIC, then a slot byte
// whose high nibble is the complement of its low nibble) on a serial pin and
// drives the SLOT/BOOT inputs of the warm-boot primitive wrapper.
// Ports:
//   clk_i  - system clock
//   rst_in - asynchronous active-low reset
//   rx_i   - serial command line (8N1, idles high)
//   slot_o - selected slot, held until the next valid command
//   boot_o - boot request, high for BOOT_HOLD cycles
//   busy_o - high while the slot is being set up or BOOT is pulsed
//   err_o  - one-cycle pulse on a framing or command-check error
module warmboot_requester
   import warmboot_pkg::*;
#(
   parameter int         CLKS_PER_BIT = 16,
   parameter logic [7:0] MAGIC        = DEFAULT_MAGIC,
   parameter int         BOOT_HOLD    = 4,
   parameter int         SLOT_W       = 4
) (
   input  logic              clk_i,
   input  logic              rst_in,
   input  logic              rx_i,
   output logic [SLOT_W-1:0] slot_o,
   output logic              boot_o,
   output logic              busy_o,
   output logic              err_o
);

   localparam int HOLD_W = $clog2(BOOT_HOLD + 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(BOOT_HOLD - 1);

   logic [7:0]        rx_byte;
   logic              byte_valid;
   logic              frame_err;

   parse_state_t      state, state_n;
   logic [HOLD_W-1:0] hold, hold_n;
   logic [SLOT_W-1:0] slot_n;
   logic              err_n;

   warmboot_uart_rx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_rx (
      .clk_i       (clk_i),
      .rst_in      (rst_in),
      .rx_i        (rx_i),
      .byte_o      (rx_byte),
      .byte_valid_o(byte_valid),
      .frame_err_o (frame_err)
   );

   // boot_o and busy_o are registered from the next state so they are
   // glitch-free at the wrapper and cleared directly by the async reset.
   always_ff @(posedge clk_i or negedge rst_in) begin
      if (!rst_in) begin
         state  <= P_IDLE;
         hold   <= '0;
         slot_o <= '0;
         err_o  <= 1'b0;
         boot_o <= 1'b0;
         busy_o <= 1'b0;
      end else begin
         state  <= state_n;
         hold   <= hold_n;
         slot_o <= slot_n;
         err_o  <= err_n;
         boot_o <= (state_n == P_PULSE);
         busy_o <= (state_n == P_SETUP) || (state_n == P_PULSE);
      end
   end

   // Bytes seen in P_SETUP/P_PULSE fall through untouched: they are dropped.
   // A framing error always reports, but only aborts a half-received command.
   always_comb begin
      state_n = state;
      hold_n  = hold;
      slot_n  = slot_o;
      err_n   = frame_err;
      case (state)
         P_IDLE: begin
            if (byte_valid && (rx_byte == MAGIC)) state_n = P_GOT_MAGIC;
         end
         P_GOT_MAGIC: begin
            if (frame_err) begin
               state_n = P_IDLE;
            end else if (byte_valid) begin
               if (cmd_byte_ok(rx_byte)) begin
                  slot_n  = SLOT_W'(rx_byte[3:0]);
                  state_n = P_SETUP;
               end else begin
                  err_n   = 1'b1;
                  state_n = P_IDLE;
               end
            end
         end
         P_SETUP: begin
            // One cycle of settled slot_o before BOOT rises.
            state_n = P_PULSE;
            hold_n  = '0;
         end
         P_PULSE: begin
            if (hold == HOLD_LAST) begin
               state_n = P_IDLE;
            end else begin
               hold_n = hold + 1'b1;
            end
         end
         default: state_n = P_IDLE;
      endcase
   end

endmodule
